span_cme_sequencer: RTL and testbench

SPAN_CME_SEQUENCER -- requirements
Module: span_cme_sequencer

---
 rtl/span_cme_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_span_cme_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/span_cme_sequencer.sv
// span_cme_sequencer: streams margin-record words into the span_cme slave,
// waits out the computation window, reads the result register and hands
// it out on a valid/ready result stream. Short and long records raise err.
//
// Handshakes (both streams): a transfer happens on a rising clk edge where
// valid and ready are both 1; the source holds data stable while valid is
// high and ready is low, and valid never drops without a transfer.
module span_cme_sequencer #(
   parameter int         NUM_WORDS     = 29,
   parameter logic [4:0] RESULT_OFFSET = 5'd31,
   parameter int         WAIT_CYCLES   = 64
) (
   input  logic        clk,
   input  logic        reset,
   // record word stream
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic        in_last,
   // span_cme slave bus master
   output logic        chipselect,
   output logic        write,
   output logic        read,
   output logic [4:0]  offset,
   output logic [15:0] writeData,
   input  logic [15:0] readData,
   // result stream
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_data,
   // status
   output logic        busy,
   output logic        err,
   output logic [15:0] rec_count,
   // debug view of the sequencer state
   output logic [2:0]  state_dbg
);

   localparam int         CNT_W    = $clog2(WAIT_CYCLES + 1);
   localparam logic [4:0] LAST_IDX = 5'(NUM_WORDS - 1);

   typedef enum logic [2:0] {
      ST_LOAD  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_READ  = 3'd2,
      ST_CAPT  = 3'd3,
      ST_OUT   = 3'd4,
      ST_DRAIN = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [4:0]         idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               in_ready_q, in_ready_d;
   logic               cs_q, cs_d;
   logic               write_q, write_d;
   logic               read_q, read_d;
   logic [4:0]         offset_q, offset_d;
   logic [15:0]        wdata_q, wdata_d;
   logic               res_valid_q, res_valid_d;
   logic [15:0]        res_data_q, res_data_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;
   logic [15:0]        rec_count_q, rec_count_d;

   // a beat is taken only when the registered ready is high
   logic               accept;
   assign accept = in_valid && in_ready_q;

   // state, word index and wait counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_LOAD;
         idx_q   <= 5'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   // next-state: record framing, wait window, read and result hand-off
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_LOAD: begin
            if (accept) begin
               if (idx_q == LAST_IDX) begin
                  idx_d = 5'd0;
                  if (in_last) begin
                     state_d = ST_WAIT;
                     cnt_d   = CNT_W'(WAIT_CYCLES);
                  end else begin
                     state_d = ST_DRAIN;
                  end
               end else if (in_last) begin
                  idx_d = 5'd0;            // short record: restart framing
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_READ;
         end
         ST_READ:  state_d = ST_CAPT;
         ST_CAPT:  state_d = ST_OUT;
         ST_OUT: begin
            if (res_valid_q && res_ready) begin
               state_d = ST_LOAD;
               idx_d   = 5'd0;
            end
         end
         ST_DRAIN: begin
            if (accept && in_last) begin
               state_d = ST_LOAD;
               idx_d   = 5'd0;
            end
         end
         default: begin
            state_d = ST_LOAD;
            idx_d   = 5'd0;
         end
      endcase
   end

   // output decode: every output is computed one cycle early and registered
   always_comb begin
      cs_d        = 1'b0;
      write_d     = 1'b0;
      read_d      = 1'b0;
      offset_d    = offset_q;
      wdata_d     = wdata_q;
      err_d       = 1'b0;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      rec_count_d = rec_count_q;

      if (state_q == ST_LOAD && accept) begin
         cs_d     = 1'b1;
         write_d  = 1'b1;
         offset_d = idx_q;
         wdata_d  = in_data;
         err_d    = in_last && (idx_q != LAST_IDX);
      end

      if (state_q == ST_DRAIN && accept && in_last) err_d = 1'b1;

      // strobe the read for the single cycle spent in READ
      if (state_q == ST_WAIT && state_d == ST_READ) begin
         cs_d     = 1'b1;
         read_d   = 1'b1;
         offset_d = RESULT_OFFSET;
      end

      // readData is valid the cycle after the strobe, i.e. while in CAPT
      if (state_q == ST_CAPT) begin
         res_data_d  = readData;
         res_valid_d = 1'b1;
      end

      if (state_q == ST_OUT && res_valid_q && res_ready) begin
         res_valid_d = 1'b0;
         rec_count_d = rec_count_q + 16'd1;
      end

      in_ready_d = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
      busy_d     = (state_d != ST_LOAD) || (idx_d != 5'd0);
   end

   // registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_ready_q  <= 1'b0;
         cs_q        <= 1'b0;
         write_q     <= 1'b0;
         read_q      <= 1'b0;
         offset_q    <= 5'd0;
         wdata_q     <= 16'd0;
         res_valid_q <= 1'b0;
         res_data_q  <= 16'd0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         rec_count_q <= 16'd0;
      end else begin
         in_ready_q  <= in_ready_d;
         cs_q        <= cs_d;
         write_q     <= write_d;
         read_q      <= read_d;
         offset_q    <= offset_d;
         wdata_q     <= wdata_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         rec_count_q <= rec_count_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign chipselect = cs_q;
   assign write      = write_q;
   assign read       = read_q;
   assign offset     = offset_q;
   assign writeData  = wdata_q;
   assign res_valid  = res_valid_q;
   assign res_data   = res_data_q;
   assign err        = err_q;
   assign busy       = busy_q;
   assign rec_count  = rec_count_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_span_cme_sequencer.sv
// Bench for span_cme_sequencer: record driver, span_cme slave model whose
// result register returns the 16-bit sum of words 0..NW-1, a scoreboard of
// expected bus writes and results, and record-level reference rules.
module tb_span_cme_sequencer;

   localparam int NW = 29;
   localparam int WC = 64;

   // clock / reset
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = 16'd0;
   logic        in_last = 1'b0;
   logic        chipselect, write, read;
   logic [4:0]  offset;
   logic [15:0] writeData;
   logic [15:0] readData;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [15:0] res_data;
   logic        busy, err;
   logic [15:0] rec_count;
   logic [2:0]  state_dbg;

   span_cme_sequencer #(.NUM_WORDS(NW), .RESULT_OFFSET(5'd31), .WAIT_CYCLES(WC)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .chipselect(chipselect), .write(write), .read(read), .offset(offset),
      .writeData(writeData), .readData(readData),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .busy(busy), .err(err), .rec_count(rec_count), .state_dbg(state_dbg)
   );

   // span_cme slave model
   logic [15:0] mem [32];

   function automatic logic [15:0] mem_sum();
      logic [15:0] s = 16'd0;
      for (int i = 0; i < NW; i++) s = s + mem[i];
      return s;
   endfunction

   always @(posedge clk) begin
      if (chipselect && write) mem[offset] <= writeData;
      if (chipselect && read) readData <= (offset == 5'd31) ? mem_sum() : mem[offset];
   end

   // scoreboard state
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [20:0] exp_wr_q[$];
   logic [15:0] exp_res_q[$];
   int          err_exp = 0;
   int          err_seen = 0;
   logic [15:0] rec_exp = 16'd0;
   int          cyc = 0;
   int          last_wr_cyc = -1000;
   logic [15:0] rec_words [40];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s", name);
   endtask

   // monitor: samples mid-cycle, pops expectations as the DUT presents outputs
   always @(negedge clk) begin
      logic [20:0] e;
      #2;
      cyc++;
      if (reset && (chipselect || write || read)) begin
         check("bus_strobe", {63'd0, chipselect && (write ^ read)}, 64'd1);
         if (write) begin
            if (exp_wr_q.size() == 0) fail("unexpected_write");
            else begin
               e = exp_wr_q.pop_front();
               check("write", {43'd0, offset, writeData}, {43'd0, e});
            end
            last_wr_cyc = cyc;
         end
         if (read) begin
            check("read_offset", {59'd0, offset}, 64'd31);
            check("read_gap", 64'(cyc - last_wr_cyc), 64'(WC));
         end
      end
      if (reset && err) err_seen++;
      if (reset && res_valid && res_ready) begin
         if (exp_res_q.size() == 0) fail("unexpected_result");
         else check("result", {48'd0, res_data}, {48'd0, exp_res_q.pop_front()});
      end
   end

   // driver: one beat, bounded wait for in_ready; returns just after the accepting edge
   task automatic send_beat(input logic [15:0] d, input logic last, output bit ok);
      int t = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) begin
         fail("in_ready_timeout");
         in_valid = 1'b0;
         ok = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      ok = 1'b1;
   endtask

   // record-level reference: first NW beats are written to offsets 0..,
   // exactly NW beats gives a result (sum), any other length gives one err
   task automatic send_record(input int len, input int n_send, input bit gaps);
      bit          ok;
      logic [15:0] s = 16'd0;
      for (int i = 0; i < len && i < NW; i++) s = s + rec_words[i];
      for (int i = 0; i < n_send; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         send_beat(rec_words[i], i == len - 1, ok);
         if (!ok) return;
         if (i < NW) exp_wr_q.push_back({5'(i), rec_words[i]});
         if (i == len - 1) begin
            if (len == NW) begin
               exp_res_q.push_back(s);
               rec_exp = rec_exp + 16'd1;
            end else begin
               err_exp++;
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic rand_words(input int len);
      for (int i = 0; i < len; i++) rec_words[i] = 16'($urandom_range(0, 65535));
   endtask

   task automatic wait_idle();
      int t = 0;
      repeat (2) @(negedge clk);
      while ((busy || res_valid || exp_res_q.size() != 0) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) fail("idle_timeout");
      repeat (2) @(negedge clk);
   endtask

   task automatic checkpoint(input string name);
      check({name, "_rec_count"}, {48'd0, rec_count}, {48'd0, rec_exp});
      check({name, "_err_count"}, 64'(err_seen), 64'(err_exp));
      check({name, "_pending_wr"}, 64'(exp_wr_q.size()), 64'd0);
      check({name, "_busy"}, {63'd0, busy}, 64'd0);
   endtask

   // watchdog
   initial begin
      #300000;
      fail("global_timeout");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "global timeout");
   end

   // main sequence
   initial begin
      int          r;
      int          len;
      logic [15:0] s;

      // reset state
      repeat (3) @(negedge clk);
      check("reset_outs", {4'd0, in_ready, chipselect, write, read, offset, writeData,
                           res_valid, res_data, err, busy, rec_count}, 64'd0);
      reset = 1'b1;
      #1;
      check("in_ready_before_edge", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
      check("in_ready_after_release", {63'd0, in_ready}, 64'd1);
      @(negedge clk);

      // normal record
      rec_words[0] = 16'd300;
      rec_words[1] = 16'd30;
      rec_words[2] = 16'd30;
      rec_words[3] = 16'hFFF6;
      rec_words[4] = 16'hFFF6;
      rec_words[5] = 16'hFFEC;
      for (int i = 6; i < NW - 1; i++) rec_words[i] = 16'd5;
      rec_words[NW-1] = 16'd120;
      send_record(NW, NW, 1'b0);
      repeat (10) @(negedge clk);
      check("busy_in_wait", {62'd0, busy, in_ready}, 64'd2);
      wait_idle();
      checkpoint("normal");

      // short record, then a full one starting at offset 0
      rand_words(10);
      send_record(10, 10, 1'b0);
      wait_idle();
      checkpoint("short");
      rand_words(NW);
      send_record(NW, NW, 1'b1);
      wait_idle();
      checkpoint("after_short");

      // long record
      rand_words(33);
      send_record(33, 33, 1'b0);
      wait_idle();
      checkpoint("long");

      // result back-pressure
      res_ready = 1'b0;
      rand_words(NW);
      s = 16'd0;
      for (int i = 0; i < NW; i++) s = s + rec_words[i];
      send_record(NW, NW, 1'b0);
      r = 0;
      while (!res_valid && r < 200) begin
         @(negedge clk);
         r++;
      end
      if (r >= 200) fail("res_valid_timeout");
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_hold", {46'd0, res_valid, in_ready, res_data}, {46'd0, 2'b10, s});
      end
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release", {62'd0, res_valid, in_ready}, 64'd1);
      wait_idle();
      checkpoint("backpressure");

      // reset mid-record
      rand_words(NW);
      send_record(NW, 15, 1'b0);
      #4;
      reset = 1'b0;
      #1;
      check("midrec_reset_outs", {4'd0, in_ready, chipselect, write, read, offset, writeData,
                                  res_valid, res_data, err, busy, rec_count}, 64'd0);
      rec_exp = 16'd0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      rand_words(NW);
      send_record(NW, NW, 1'b1);
      wait_idle();
      checkpoint("after_reset");

      // randomized records
      for (int k = 0; k < 12; k++) begin
         r = $urandom_range(0, 3);
         if (r < 2) len = NW;
         else if (r == 2) len = $urandom_range(1, NW - 1);
         else len = $urandom_range(NW + 1, NW + 6);
         rand_words(len);
         send_record(len, len, 1'b1);
      end
      wait_idle();
      checkpoint("random");

      // rec_count wrap
      @(negedge clk);
      force dut.rec_count_q = 16'hFFFF;
      @(posedge clk);
      @(negedge clk);
      release dut.rec_count_q;
      @(negedge clk);
      check("preset_ffff", {48'd0, rec_count}, 64'hFFFF);
      rec_exp = 16'hFFFF;
      rand_words(NW);
      send_record(NW, NW, 1'b0);
      wait_idle();
      check("wrap_zero", {48'd0, rec_count}, 64'd0);
      checkpoint("wrap");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
